ift_taint_monitor: RTL
======================

# ift_taint_monitor

Downstream observer for IFT designs under test: samples a DUT output bit `c` and its taint vector `c_t`, timestamps every change of `{c, c_t}` and buffers the change events in a small FIFO drained over a valid/ready port. It also records the first cycle at which any taint appears and counts tainted cycles. Benches and on-chip harnesses use it to measure taint propagation latency and to log taint behaviour without per-cycle VCD dumps.

## Interface
Parameters:
- `TAINT_W`, 32: width of `c_t`.
- `TS_W`, 32: width of timestamp and counters.
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: clock; all logic is rising-edge.
- `rst` in 1: reset; synchronous, active-high.
- `arm` in 1: single-cycle pulse that starts or restarts a measurement.
- `stop` in 1: single-cycle pulse that ends the measurement and freezes the results.
- `c` in 1: DUT data output.
- `c_t` in `TAINT_W`: DUT taint vector for `c`.
- `evt_valid` out 1: the FIFO head is valid.
- `evt_ready` in 1: consumer accepts the head.
- `evt_data` out `TS_W+TAINT_W+1`: FIFO head `{ts, c_t, c}`.
- `first_seen` out 1: a nonzero `c_t` has been seen since `arm`.
- `first_time` out `TS_W`: timestamp of the first nonzero `c_t`.
- `taint_cycles` out `TS_W`: number of cycles with nonzero `c_t`; saturates at all-ones.
- `overflow` out 1: sticky flag; at least one event was dropped.
- `active` out 1: state is ARMED or TRACKING.

## Operation
- **States.**
  - IDLE: reset state.
  - ARMED: armed, no taint seen yet.
  - TRACKING: taint seen.
- **Transitions.**
  - IDLE –`arm`→ ARMED.
  - ARMED –nonzero `c_t` and no `arm`→ TRACKING.
  - ARMED or TRACKING –`stop`→ IDLE.
  - `arm` in any state → ARMED (restart).
  - `arm` and `stop` in the same cycle: `arm` wins.
- **Effects of `arm`.**
  - `ts` ← 0; `first_seen`, `first_time`, `taint_cycles` and `overflow` are cleared.
  - `prev` ← current `{c, c_t}`.
  - No event is generated in the `arm` cycle.
  - The FIFO is not flushed, so events still pending remain readable.
- **Timestamp `ts`.**
  - Increments every cycle in ARMED or TRACKING.
  - Saturates at 2^TS_W−1 and does not wrap.
  - Holds its value in IDLE.
- **Event rule.**
  - A cycle in ARMED or TRACKING (not an `arm` cycle) with `{c, c_t} != prev` produces event `{ts, c_t, c}`.
  - `prev` updates every active cycle.
  - No events are generated in IDLE, and `prev` holds in IDLE.
- **First taint.** In ARMED, nonzero `c_t` sets `first_seen` = 1 and `first_time` = `ts` of that cycle. These values hold until the next `arm` or `rst`.
- **Tainted-cycle count.** `taint_cycles` increments in each active, non-`arm` cycle with nonzero `c_t`, saturating.
- **FIFO.**
  - Push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the event is dropped and `overflow` ← 1.
  - Pop occurs when `evt_valid & evt_ready`.
  - Push and pop in the same cycle on an empty FIFO: there is no pop. The event is written and becomes visible in the next cycle.
- **`stop` cycle.** The cycle in which `stop` is sampled still evaluates the event and count rules.

## Timing
- **Reset values.** State IDLE, `ts`=0, `prev`=0, FIFO empty. `evt_valid`=0, `evt_data`=0, `first_seen`=0, `first_time`=0, `taint_cycles`=0, `overflow`=0, `active`=0.
- **Sampling.** `c` and `c_t` are sampled combinationally at each edge; there is no input register.
- **Event latency.** An event detected in cycle N gives `evt_valid`=1 from cycle N+1 with `evt_data` = that event.
- **Registered outputs.** `first_*`, `taint_cycles`, `overflow` and `active` are registers and update one edge after the causing condition.
- **Timestamp origin.** The first cycle after `arm` has `ts`=0.
- **Hold while stalled.** `evt_data` is stable while `evt_valid & !evt_ready`.
- **Throughput.** One push and one pop per cycle sustained.
- **Reset mid-operation.** A `rst` mid-operation discards the FIFO contents and all state in the same edge.

## Test plan
- **Reset, then first taint.** `rst`, then `arm` with `c`=0, `c_t`=0. Hold for 3 cycles, then `c_t`=32'h1.
  - `first_seen`=1, `first_time`=3, `active`=1.
  - One event `{ts=3, c_t=1, c=0}` with `evt_valid` one cycle later.
- **Change sequence.** Sequence `{a=0,b=1}`-style changes of `c`/`c_t` at `ts` = 2, 5, 6 with `evt_ready`=1.
  - Exactly 3 events, in order, with those timestamps.
  - `taint_cycles` equals the number of nonzero-`c_t` cycles.
- **Overflow.** `evt_ready`=0 and 10 consecutive changes with `FIFO_DEPTH`=8.
  - 8 events are stored, `overflow`=1.
  - Draining returns the first 8 in order.
  - `arm` clears `overflow` but keeps the pending events.
- **Full FIFO with simultaneous pop.** Full FIFO, `evt_ready`=1 and a new change in the same cycle.
  - Push accepted, `overflow` stays 0, occupancy stays 8.
- **Control collisions.**
  - `arm` and `stop` in the same cycle → ARMED, `ts`=0.
  - `stop` → IDLE; then `c_t` changes → no events, `ts`/`taint_cycles` frozen.
  - `arm` in the same cycle as a change → no event.
- **Saturation and mid-run reset.** `TS_W`=4, run 20 cycles with `c_t` nonzero.
  - `ts` and `taint_cycles` saturate at 15.
  - `rst` mid-run → all outputs return to their reset values after one edge.

Source files
------------

// File: rtl/ift_taint_monitor.sv
// ift_taint_monitor: observes a DUT output bit and its taint vector.
// Timestamps every change of {c, c_t} into a small event FIFO, records the
// first tainted cycle and counts tainted cycles for latency/propagation studies.
module ift_taint_monitor #(
  parameter int TAINT_W    = 32,
  parameter int TS_W       = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm,
  input  logic                      stop,
  input  logic                      c,
  input  logic [TAINT_W-1:0]        c_t,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [TS_W+TAINT_W:0]     evt_data,
  output logic                      first_seen,
  output logic [TS_W-1:0]           first_time,
  output logic [TS_W-1:0]           taint_cycles,
  output logic                      overflow,
  output logic                      active
);

  localparam int EW = TS_W + TAINT_W + 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]     FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [TS_W-1:0] TS_MAX   = {TS_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    TRACKING = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [TS_W-1:0]   ts;
  logic [TAINT_W:0]  prev;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  logic              in_active;
  logic              tainted;
  logic [TAINT_W:0]  cur;
  logic              push;
  logic              pop;
  logic              accept;
  logic              drop;

  // Event detection and FIFO handshake decisions for the current cycle.
  always_comb begin
    in_active = (state != IDLE);
    tainted   = (c_t != {TAINT_W{1'b0}});
    cur       = {c, c_t};
    push      = in_active & ~arm & (cur != prev);
    pop       = (count != {(AW+1){1'b0}}) & evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    accept    = push & ((count != FULL_CNT) | pop);
    drop      = push & ~accept;
  end

  // Next-state logic; arm restarts from any state and beats stop.
  always_comb begin
    state_next = state;
    if (arm) begin
      state_next = ARMED;
    end else begin
      case (state)
        IDLE:     state_next = IDLE;
        ARMED:    state_next = stop ? IDLE : (tainted ? TRACKING : ARMED);
        TRACKING: state_next = stop ? IDLE : TRACKING;
        default:  state_next = IDLE;
      endcase
    end
  end

  // State register with a registered copy of the active flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      active <= 1'b0;
    end else begin
      state  <= state_next;
      active <= (state_next != IDLE);
    end
  end

  // Timestamp, change history, first-taint capture, taint count and overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts           <= {TS_W{1'b0}};
      prev         <= {(TAINT_W+1){1'b0}};
      first_seen   <= 1'b0;
      first_time   <= {TS_W{1'b0}};
      taint_cycles <= {TS_W{1'b0}};
      overflow     <= 1'b0;
    end else if (arm) begin
      ts           <= {TS_W{1'b0}};
      prev         <= cur;
      first_seen   <= 1'b0;
      first_time   <= {TS_W{1'b0}};
      taint_cycles <= {TS_W{1'b0}};
      overflow     <= 1'b0;
    end else if (in_active) begin
      prev <= cur;
      if (ts != TS_MAX) begin
        ts <= ts + TS_W'(1);
      end else begin
        ts <= ts;
      end
      if ((state == ARMED) && tainted) begin
        first_seen <= 1'b1;
        first_time <= ts;
      end else begin
        first_seen <= first_seen;
        first_time <= first_time;
      end
      if (tainted && (taint_cycles != TS_MAX)) begin
        taint_cycles <= taint_cycles + TS_W'(1);
      end else begin
        taint_cycles <= taint_cycles;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else begin
        overflow <= overflow;
      end
    end else begin
      ts           <= ts;
      prev         <= prev;
      first_seen   <= first_seen;
      first_time   <= first_time;
      taint_cycles <= taint_cycles;
      overflow     <= overflow;
    end
  end

  // Event FIFO storage, pointers and occupancy; reset clears the contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= {EW{1'b0}};
      end
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (accept) begin
        mem[wr_ptr] <= {ts, c_t, c};
        wr_ptr      <= wr_ptr + AW'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({accept, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Head of the FIFO is presented straight from storage registers.
  always_comb begin
    evt_valid = (count != {(AW+1){1'b0}});
    evt_data  = mem[rd_ptr];
  end

endmodule
